// File: rtl/flags.sv
// Condition-code register {V,C,N,Z} for the 16-bit core.
// Captures ALU status under flags_en (optionally per-bit masked); flags_load restores the whole word.
module flags #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         USE_MASK    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flags_en,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic [3:0] alu_mask,
  input  logic       flags_load,
  input  logic [3:0] flags_in,
  output logic       zero_flag,
  output logic       negative_flag,
  output logic       carry_flag,
  output logic       overflow_flag,
  output logic [3:0] flags_out
);

  logic [3:0] alu_flags;
  logic [3:0] eff_mask;
  logic [3:0] flags_next;
  logic [3:0] flags_reg;

  assign alu_flags = {alu_overflow, alu_carry, alu_negative, alu_zero};
  assign eff_mask  = USE_MASK ? alu_mask : 4'b1111;

  // Restore beats capture; capture only touches bits whose mask bit is set.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      assign flags_next[gi] = flags_load                  ? flags_in[gi]  :
                              (flags_en && eff_mask[gi])  ? alu_flags[gi] :
                                                            flags_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_reg <= RESET_FLAGS;
    else        flags_reg <= flags_next;
  end

  assign zero_flag     = flags_reg[0];
  assign negative_flag = flags_reg[1];
  assign carry_flag    = flags_reg[2];
  assign overflow_flag = flags_reg[3];
  assign flags_out     = {overflow_flag, carry_flag, negative_flag, zero_flag};

endmodule

// File: tb/tb_flags.sv
// Bench for flags: directed scenarios followed by randomized traffic against a reference model.
module tb_flags;
  logic       clk = 1'b0;
  logic       reset;
  logic       flags_en;
  logic       alu_zero, alu_negative, alu_carry, alu_overflow;
  logic [3:0] alu_mask;
  logic       flags_load;
  logic [3:0] flags_in;
  logic       zero_flag, negative_flag, carry_flag, overflow_flag;
  logic [3:0] flags_out;

  int checks = 0;
  int failures = 0;
  logic [3:0] model;

  flags #(.RESET_FLAGS(4'b0000), .USE_MASK(1'b1)) dut (
    .clk(clk), .reset(reset), .flags_en(flags_en),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_mask(alu_mask), .flags_load(flags_load), .flags_in(flags_in),
    .zero_flag(zero_flag), .negative_flag(negative_flag),
    .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  task automatic set_alu(input logic [3:0] v);
    {alu_overflow, alu_carry, alu_negative, alu_zero} = v;
  endtask

  // Reference: what the four flags should be after one edge with the current inputs.
  function automatic logic [3:0] predict(input logic [3:0] cur);
    logic [3:0] alu;
    logic [3:0] r;
    alu = {alu_overflow, alu_carry, alu_negative, alu_zero};
    r = cur;
    if (!reset) r = 4'b0000;
    else if (flags_load) r = flags_in;
    else if (flags_en)
      for (int i = 0; i < 4; i++)
        if (alu_mask[i]) r[i] = alu[i];
    return r;
  endfunction

  // One edge: predict, clock, then compare both the word and the individual bits.
  task automatic cycle(input string tag);
    logic [3:0] nxt;
    nxt = predict(model);
    @(posedge clk);
    #1;
    model = nxt;
    check(tag, flags_out, model);
    check({tag, "_bits"}, {overflow_flag, carry_flag, negative_flag, zero_flag}, model);
  endtask

  initial begin
    reset = 1'b0; flags_en = 1'b1; alu_mask = 4'b1111;
    flags_load = 1'b0; flags_in = 4'b0000;
    set_alu(4'b1111);
    model = 4'b0000;

    // 1. reset dominates enable
    #1 check("reset_async", flags_out, 4'b0000);
    repeat (2) cycle("reset_hold");
    @(negedge clk); reset = 1'b1;
    cycle("first_capture");

    // 2. capture then hold
    flags_en = 1'b0; set_alu(4'b0000);
    repeat (5) cycle("hold");

    // 3. sequential rise then fall
    flags_en = 1'b1; set_alu(4'b0000);
    cycle("seq_clear");
    for (int i = 0; i < 4; i++) begin
      set_alu(4'((1 << (i + 1)) - 1));
      cycle("seq_rise");
    end
    for (int i = 0; i < 4; i++) begin
      set_alu(4'(4'b1111 >> (i + 1)));
      cycle("seq_fall");
    end

    // 4. mask
    set_alu(4'b1111); cycle("mask_prep");
    alu_mask = 4'b0101; set_alu(4'b0000);
    cycle("mask");
    check("mask_const", flags_out, 4'b1010);
    alu_mask = 4'b1111;

    // 5. restore beats capture
    flags_load = 1'b1; flags_in = 4'b1001;
    cycle("restore");
    check("restore_const", flags_out, 4'b1001);
    flags_load = 1'b0;

    // 6. async reset between edges
    set_alu(4'b1111); cycle("async_prep");
    flags_en = 1'b0;
    #2 reset = 1'b0;
    #1 model = 4'b0000;
    check("async_pulse", flags_out, model);
    #1 reset = 1'b1;
    repeat (2) cycle("async_after");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      reset      = ($urandom_range(0, 29) != 0);
      flags_load = ($urandom_range(0, 7) == 0);
      flags_en   = $urandom_range(0, 1);
      alu_mask   = 4'($urandom);
      flags_in   = 4'($urandom);
      set_alu(4'($urandom));
      cycle("rand");
      reset = 1'b1;
      if ($urandom_range(0, 24) == 0) begin
        #2 reset = 1'b0;
        #1 model = 4'b0000;
        check("rand_async", flags_out, model);
        #1 reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
